lda_line_engine: RTL and testbench

- Parametrised line/fill engine for the line-drawing accelerator; the successor to the first-generation LDA datapath.
- Accepts commands through a valid/ready handshake: LINE (Bresenham, all octants) or FILL (raster fill of the whole canvas with one colour).
- Emits one pixel per accepted beat on a pixel stream with back-pressure toward the VGA/framebuffer writer.
- Sits between the LDA control/register interface and the pixel writer.

---
 rtl/lda_line_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_lda_line_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lda_line_engine.sv
// Line/fill pixel engine: Bresenham lines in all octants, or a raster fill of the whole canvas.
// Optional build macro LDA_CLIP_EN: off-canvas LINE pixels are suppressed and LINE steps every cycle.
module lda_line_engine #(
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int CW       = 3,
  parameter int SCREEN_W = 336,
  parameter int SCREEN_H = 210
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_op,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y1,
  input  logic [CW-1:0] i_color,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [CW-1:0] o_color,
  output logic          o_plot,
  input  logic          i_pix_ready,
  output logic          o_busy,
  output logic          o_done
);
  localparam int MW = (XW > YW) ? XW : YW;
  localparam int EW = MW + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LINE  = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [MW-1:0] ONE_M       = MW'(1);
  localparam logic [MW-1:0] FILL_X_LAST = MW'(SCREEN_W - 1);
  localparam logic [MW-1:0] FILL_Y_LAST = MW'(SCREEN_H - 1);

  logic [2:0]           state_q, state_d;
  logic [MW-1:0]        lx0_q, lx0_d, ly0_q, ly0_d, lx1_q, lx1_d, ly1_q, ly1_d;
  logic [CW-1:0]        color_q, color_d;
  logic                 steep_q, steep_d, yup_q, yup_d, ydn_q, ydn_d;
  logic [MW-1:0]        x_q, x_d, y_q, y_d, xend_q, xend_d;
  logic [MW-1:0]        dx_q, dx_d, dy_q, dy_d;
  logic signed [EW-1:0] err_q, err_d;

  // Octant normalisation of the latched endpoints, consumed in SETUP.
  logic [MW-1:0] adx, ady, ax0, ay0, ax1, ay1;
  logic [MW-1:0] sx0, sy0, sx1, sy1, s_dx, s_dy;
  logic          s_steep, s_swap;
  logic signed [EW-1:0] err_init;

  assign adx     = (lx1_q >= lx0_q) ? lx1_q - lx0_q : lx0_q - lx1_q;
  assign ady     = (ly1_q >= ly0_q) ? ly1_q - ly0_q : ly0_q - ly1_q;
  assign s_steep = ady > adx;
  assign ax0     = s_steep ? ly0_q : lx0_q;
  assign ay0     = s_steep ? lx0_q : ly0_q;
  assign ax1     = s_steep ? ly1_q : lx1_q;
  assign ay1     = s_steep ? lx1_q : ly1_q;
  assign s_swap  = ax0 > ax1;
  assign sx0     = s_swap ? ax1 : ax0;
  assign sy0     = s_swap ? ay1 : ay0;
  assign sx1     = s_swap ? ax0 : ax1;
  assign sy1     = s_swap ? ay0 : ay1;
  assign s_dx    = sx1 - sx0;
  assign s_dy    = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
  assign err_init = -$signed({2'b00, (s_dx >> 1)});

  // Two guard bits keep err within range: it stays in (-dx, dy].
  logic signed [EW-1:0] dx_s, dy_s, err_sum;
  logic                 y_step;

  assign dx_s    = $signed({2'b00, dx_q});
  assign dy_s    = $signed({2'b00, dy_q});
  assign err_sum = err_q + dy_s;
  assign y_step  = !err_sum[EW-1] && (err_sum != '0);

  logic line_plot, line_adv;

`ifdef LDA_CLIP_EN
  localparam logic [MW:0] W_LIM = (MW+1)'(SCREEN_W);
  localparam logic [MW:0] H_LIM = (MW+1)'(SCREEN_H);

  assign line_plot = steep_q ? (({1'b0, y_q} < W_LIM) && ({1'b0, x_q} < H_LIM))
                             : (({1'b0, x_q} < W_LIM) && ({1'b0, y_q} < H_LIM));
  assign line_adv  = 1'b1;
`else
  assign line_plot = 1'b1;
  assign line_adv  = i_pix_ready;
`endif

  always_comb begin
    state_d = state_q;
    lx0_d   = lx0_q;
    ly0_d   = ly0_q;
    lx1_d   = lx1_q;
    ly1_d   = ly1_q;
    color_d = color_q;
    steep_d = steep_q;
    yup_d   = yup_q;
    ydn_d   = ydn_q;
    x_d     = x_q;
    y_d     = y_q;
    xend_d  = xend_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          lx0_d   = MW'(i_x0);
          ly0_d   = MW'(i_y0);
          lx1_d   = MW'(i_x1);
          ly1_d   = MW'(i_y1);
          color_d = i_color;
          if (i_cmd_op) begin
            x_d     = '0;
            y_d     = '0;
            steep_d = 1'b0;
            state_d = S_FILL;
          end else begin
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        steep_d = s_steep;
        x_d     = sx0;
        y_d     = sy0;
        xend_d  = sx1;
        dx_d    = s_dx;
        dy_d    = s_dy;
        yup_d   = sy1 > sy0;
        ydn_d   = sy1 < sy0;
        err_d   = err_init;
        state_d = S_LINE;
      end

      S_LINE: begin
        if (line_adv) begin
          if (x_q == xend_q) begin
            state_d = S_DONE;
          end else begin
            x_d = x_q + ONE_M;
            if (y_step) begin
              if (yup_q) y_d = y_q + ONE_M;
              else if (ydn_q) y_d = y_q - ONE_M;
              err_d = err_sum - dx_s;
            end else begin
              err_d = err_sum;
            end
          end
        end
      end

      S_FILL: begin
        if (i_pix_ready) begin
          if (x_q == FILL_X_LAST) begin
            if (y_q == FILL_Y_LAST) begin
              state_d = S_DONE;
            end else begin
              x_d = '0;
              y_d = y_q + ONE_M;
            end
          end else begin
            x_d = x_q + ONE_M;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lx0_q   <= '0;
      ly0_q   <= '0;
      lx1_q   <= '0;
      ly1_q   <= '0;
      color_q <= '0;
      steep_q <= 1'b0;
      yup_q   <= 1'b0;
      ydn_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      xend_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lx0_q   <= lx0_d;
      ly0_q   <= ly0_d;
      lx1_q   <= lx1_d;
      ly1_q   <= ly1_d;
      color_q <= color_d;
      steep_q <= steep_d;
      yup_q   <= yup_d;
      ydn_q   <= ydn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xend_q  <= xend_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
    end
  end

  // Steep lines walk along y internally, so the axes swap back on the way out.
  assign o_x         = steep_q ? y_q[XW-1:0] : x_q[XW-1:0];
  assign o_y         = steep_q ? x_q[YW-1:0] : y_q[YW-1:0];
  assign o_color     = color_q;
  assign o_plot      = ((state_q == S_LINE) && line_plot) || (state_q == S_FILL);
  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_lda_line_engine.sv
// Bench for lda_line_engine on a 4x3 canvas: directed table, hand sequences and random commands
// checked against a closed-form Bresenham reference model.
module tb_lda_line_engine;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;
  localparam int SW = 4;
  localparam int SH = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          i_cmd_op = 1'b0;
  logic [XW-1:0] i_x0 = '0, i_x1 = '0;
  logic [YW-1:0] i_y0 = '0, i_y1 = '0;
  logic [CW-1:0] i_color = '0;
  logic          i_pix_ready = 1'b0;
  logic          o_cmd_ready, o_plot, o_busy, o_done;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic [CW-1:0] o_color;

  lda_line_engine #(.XW(XW), .YW(YW), .CW(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1), .i_color(i_color),
    .o_x(o_x), .o_y(o_y), .o_color(o_color), .o_plot(o_plot),
    .i_pix_ready(i_pix_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_x[$], exp_y[$];
  int exp_steps;
  int exp_color;
  int cap_x[$], cap_y[$];

  typedef struct {
    bit op;
    int x0, y0, x1, y1, c, mode;
    int bn, bc;      // beats expected without / with clipping
    int lx, ly;      // last pixel without clipping (-1: none)
    int lcx, lcy;    // last pixel with clipping (-1: none)
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: the y offset after i major-axis steps is ceil((i*dy - dx/2) / dx).
  task automatic model(input bit op, input int x0, input int y0, input int x1, input int y1);
    int ax0, ay0, ax1, ay1, t, dx, dy, ys, h, k, px, py, qx, qy;
    bit steep;
    exp_x.delete();
    exp_y.delete();
    if (op) begin
      for (int yy = 0; yy < SH; yy++)
        for (int xx = 0; xx < SW; xx++) begin
          exp_x.push_back(xx);
          exp_y.push_back(yy);
        end
      exp_steps = SW * SH;
      return;
    end
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    ax0 = steep ? y0 : x0; ay0 = steep ? x0 : y0;
    ax1 = steep ? y1 : x1; ay1 = steep ? x1 : y1;
    if (ax0 > ax1) begin
      t = ax0; ax0 = ax1; ax1 = t;
      t = ay0; ay0 = ay1; ay1 = t;
    end
    dx = ax1 - ax0;
    dy = iabs(ay1 - ay0);
    ys = (ay1 > ay0) ? 1 : ((ay1 < ay0) ? -1 : 0);
    h  = dx / 2;
    exp_steps = dx + 1;
    for (int i = 0; i <= dx; i++) begin
      k  = (dx == 0) ? 0 : (i * dy - h + dx - 1) / dx;
      px = ax0 + i;
      py = ay0 + ys * k;
      qx = steep ? py : px;
      qy = steep ? px : py;
`ifdef LDA_CLIP_EN
      if (qx >= SW || qy >= SH) continue;
`endif
      exp_x.push_back(qx);
      exp_y.push_back(qy);
    end
  endtask

  task automatic run_cmd(input bit op, input int x0, input int y0, input int x1, input int y1,
                         input int c, input int mode, output int nbeats);
    int cyc, first_plot, last_beat, done_cyc, wait_n, hx, hy, hc, px, py;
    bit rdy, hold, beat, free_run, seen_done;
    model(op, x0, y0, x1, y1);
    exp_color = c;
    cap_x.delete();
    cap_y.delete();
    nbeats = 0; first_plot = -1; last_beat = -1; done_cyc = -1;
    hold = 1'b0; seen_done = 1'b0; hx = 0; hy = 0; hc = 0;
`ifdef LDA_CLIP_EN
    free_run = !op;
`else
    free_run = 1'b0;
`endif
    wait_n = 0;
    @(negedge clk);
    while (!o_cmd_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk("cmd_ready_idle", int'(o_cmd_ready), 1);
    i_cmd_op = op; i_x0 = XW'(x0); i_y0 = YW'(y0); i_x1 = XW'(x1); i_y1 = YW'(y1);
    i_color = CW'(c); i_cmd_valid = 1'b1; i_pix_ready = 1'b1;
    @(posedge clk);
    for (cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        // Scramble the command inputs: the engine must have latched them already.
        i_cmd_valid = 1'b0; i_cmd_op = ~op;
        i_x0 = XW'($urandom); i_y0 = YW'($urandom);
        i_x1 = XW'($urandom); i_y1 = YW'($urandom); i_color = CW'($urandom);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3) == 2;
        default: rdy = ($urandom % 4) != 0;
      endcase
      i_pix_ready = rdy;
      chk("ready_low_busy", int'(o_cmd_ready), 0);
      if (hold) begin
        chk("hold_x", int'(o_x), hx);
        chk("hold_y", int'(o_y), hy);
        chk("hold_color", int'(o_color), hc);
        chk("hold_plot", int'(o_plot), 1);
      end
      if (o_plot && first_plot < 0) first_plot = cyc;
      beat = o_plot && (rdy || free_run);
      if (beat) begin
        nbeats++;
        last_beat = cyc;
        cap_x.push_back(int'(o_x));
        cap_y.push_back(int'(o_y));
        chk("pixel_available", int'(exp_x.size() > 0), 1);
        if (exp_x.size() > 0) begin
          px = exp_x.pop_front();
          py = exp_y.pop_front();
          chk("pix_x", int'(o_x), px);
          chk("pix_y", int'(o_y), py);
          chk("pix_color", int'(o_color), exp_color);
        end
      end
      hold = o_plot && !rdy && !free_run;
      hx = int'(o_x); hy = int'(o_y); hc = int'(o_color);
      if (o_done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        chk("done_no_plot", int'(o_plot), 0);
        chk("done_busy", int'(o_busy), 1);
      end else begin
        chk("busy", int'(o_busy), 1);
      end
    end
    chk("done_seen", int'(seen_done), 1);
    if (seen_done) begin
      @(negedge clk);
      chk("idle_ready", int'(o_cmd_ready), 1);
      chk("idle_busy", int'(o_busy), 0);
      chk("done_one_cycle", int'(o_done), 0);
    end
    chk("pixels_left", exp_x.size(), 0);
    if (op) chk("fill_latency", first_plot, 1);
    else if (!free_run) chk("line_latency", first_plot, 2);
    if (free_run) chk("clip_done_cycle", done_cyc, exp_steps + 2);
    else if (nbeats > 0) chk("done_after_last", done_cyc - last_beat, 1);
  endtask

  int nb, n, exp_b, exp_lx, exp_ly;
  int sh_x[7];
  int sh_y[7];

  initial begin
    tbl[0] = '{1'b0, 2, 3, 8, 5, 5, 0,     7,  0,   8,   5,  -1, -1};
    tbl[1] = '{1'b0, 4, 10, 2, 2, 1, 0,    9,  1,   4,  10,   2,  2};
    tbl[2] = '{1'b0, 7, 7, 7, 7, 3, 0,     1,  0,   7,   7,  -1, -1};
    tbl[3] = '{1'b0, 0, 0, 5, 0, 6, 1,     6,  4,   5,   0,   3,  0};
    tbl[4] = '{1'b1, 0, 0, 0, 0, 2, 0,    12, 12,   3,   2,   3,  2};
    tbl[5] = '{1'b0, 0, 0, 6, 0, 4, 0,     7,  4,   6,   0,   3,  0};
    tbl[6] = '{1'b0, 3, 2, 0, 0, 7, 2,     4,  4,   3,   2,   3,  2};
    tbl[7] = '{1'b0, 0, 0, 511, 255, 1, 0, 512, 4, 511, 255,   3,  1};
    tbl[8] = '{1'b1, 0, 0, 0, 0, 5, 2,    12, 12,   3,   2,   3,  2};
    sh_x = '{2, 3, 4, 5, 6, 7, 8};
    sh_y = '{3, 3, 4, 4, 4, 5, 5};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(o_cmd_ready), 1);
    chk("rst_plot", int'(o_plot), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_x", int'(o_x), 0);
    chk("rst_y", int'(o_y), 0);
    chk("rst_color", int'(o_color), 0);
    reset = 1'b0;

    // Reset in the middle of a line abandons it without a done pulse
    @(negedge clk);
    i_cmd_op = 1'b0; i_x0 = 0; i_y0 = 0; i_x1 = 20; i_y1 = 5; i_color = 3;
    i_cmd_valid = 1'b1; i_pix_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    n = 0;
    for (int g = 0; g < 20 && n < 3; g++) begin
      if (o_plot) n++;
      if (n < 3) @(negedge clk);
    end
    chk("rst_mid_beats", n, 3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_plot", int'(o_plot), 0);
    chk("rst_mid_ready", int'(o_cmd_ready), 1);
    chk("rst_mid_busy", int'(o_busy), 0);
    chk("rst_mid_done", int'(o_done), 0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("rst_mid_no_done", int'(o_done), 0);
      chk("rst_mid_no_plot", int'(o_plot), 0);
    end

    // Shallow line against the literal pixel list
    run_cmd(1'b0, 2, 3, 8, 5, 5, 0, nb);
`ifndef LDA_CLIP_EN
    chk("shallow_beats", nb, 7);
    for (int i = 0; i < 7 && i < cap_x.size(); i++) begin
      chk("shallow_x", cap_x[i], sh_x[i]);
      chk("shallow_y", cap_y[i], sh_y[i]);
    end
`endif

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].op, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].c, tbl[i].mode, nb);
`ifdef LDA_CLIP_EN
      exp_b = tbl[i].bc; exp_lx = tbl[i].lcx; exp_ly = tbl[i].lcy;
`else
      exp_b = tbl[i].bn; exp_lx = tbl[i].lx; exp_ly = tbl[i].ly;
`endif
      chk($sformatf("tbl%0d_beats", i), nb, exp_b);
      if (exp_lx >= 0 && cap_x.size() > 0) begin
        chk($sformatf("tbl%0d_last_x", i), cap_x[cap_x.size()-1], exp_lx);
        chk($sformatf("tbl%0d_last_y", i), cap_y[cap_y.size()-1], exp_ly);
      end
    end

    // Random commands against the reference model
    for (int r = 0; r < 40; r++) begin
      run_cmd(($urandom % 6) == 0, int'($urandom_range(0, 30)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 30)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), nb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
